// File: rtl/debug_display_ctrl.sv
// Debug display controller: converts a selected pipeline PC, register or flag set
// into a multi-digit 7-segment image, one digit per cycle, committed atomically.
module debug_display_ctrl #(
    parameter int unsigned NUM_STAGES = 7,
    parameter int unsigned PC_W       = 7,
    parameter int unsigned OP_W       = 7,
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned VAL_W      = 20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_STAGES*PC_W-1:0] pc_bus,
    input  logic [NUM_STAGES*OP_W-1:0] opcode_bus,
    input  logic [31:0]                selected_register,
    input  logic [31:0]                status_register,
    input  logic [9:0]                 SW,
    output logic [NUM_DIGITS*7-1:0]    HEX,
    output logic [9:0]                 LEDR,
    output logic                       busy
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned SEG_W = 7;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {CAPTURE, CONVERT, COMMIT} state_t;

    state_t                    state;
    logic [VAL_W-1:0]          val_sh;
    logic [3:0]                flags_sh;
    logic [9:0]                sw_sh;
    logic [NUM_DIGITS*4-1:0]   raw;
    logic [CNT_W-1:0]          cnt;
    logic [NUM_DIGITS*SEG_W-1:0] hex_q;

    logic [VAL_W-1:0]          sel_val_c;
    logic [OP_W-1:0]           sel_op_c;
    logic [3:0]                digit_c;
    logic [VAL_W-1:0]          val_next_c;
    logic [NUM_DIGITS*SEG_W-1:0] image_c;
    logic [7:0]                flags_ext_c;
    logic                      upper_zero_c;
    logic                      overflow_c;
    logic                      unused_c;

    function automatic logic [SEG_W-1:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Source select; out-of-range stage reads as zero value and zero opcode
    always_comb begin
        sel_val_c = '0;
        sel_op_c  = '0;
        if (SW[8]) begin
            sel_val_c = selected_register[VAL_W-1:0];
        end
        for (int s = 0; s < NUM_STAGES; s++) begin
            if (SW[2:0] == 3'(s)) begin
                if (!SW[8]) begin
                    sel_val_c = VAL_W'(pc_bus[s*PC_W +: PC_W]);
                end
                sel_op_c = opcode_bus[s*OP_W +: OP_W];
            end
        end
    end

    // One radix step per CONVERT cycle
    always_comb begin
        digit_c    = '0;
        val_next_c = '0;
        if (sw_sh[6]) begin
            digit_c    = val_sh[3:0];
            val_next_c = val_sh >> 4;
        end else begin
            digit_c    = 4'(val_sh % VAL_W'(10));
            val_next_c = val_sh / VAL_W'(10);
        end
    end

    // Final image: leftover value after all digits means it did not fit
    always_comb begin
        image_c      = '0;
        flags_ext_c  = 8'(flags_sh);
        upper_zero_c = 1'b1;
        overflow_c   = (val_sh != '0);
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            upper_zero_c = upper_zero_c & (raw[d*4 +: 4] == 4'd0);
            if (sw_sh[7]) begin
                image_c[d*SEG_W +: SEG_W] = (d < 4) ? seg7({3'b000, flags_ext_c[d]}) : SEG_BLANK;
            end else if (overflow_c) begin
                image_c[d*SEG_W +: SEG_W] = SEG_DASH;
            end else if ((d != 0) && upper_zero_c) begin
                image_c[d*SEG_W +: SEG_W] = SEG_BLANK;
            end else begin
                image_c[d*SEG_W +: SEG_W] = seg7(raw[d*4 +: 4]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CAPTURE;
            hex_q    <= '1;
            busy     <= 1'b0;
            val_sh   <= '0;
            flags_sh <= '0;
            sw_sh    <= '0;
            raw      <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                CAPTURE: begin
                    if (SW[9]) begin
                        val_sh   <= sel_val_c;
                        flags_sh <= status_register[31:28];
                        sw_sh    <= SW;
                        raw      <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (SW != sw_sh) begin
                        busy  <= 1'b0;
                        state <= CAPTURE;
                    end else begin
                        // LSD enters at the top and ends up at digit 0 after the last shift
                        raw    <= {digit_c, raw[NUM_DIGITS*4-1:4]};
                        val_sh <= val_next_c;
                        cnt    <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(NUM_DIGITS - 1)) begin
                            state <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    if (SW == sw_sh) begin
                        hex_q <= image_c;
                    end
                    busy  <= 1'b0;
                    state <= CAPTURE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= CAPTURE;
                end
            endcase
        end
    end

    assign HEX  = SW[9] ? hex_q : '1;
    assign LEDR = !SW[9] ? 10'h3FF : (SW[8] ? 10'h000 : 10'(sel_op_c));

    assign unused_c = ^{status_register, selected_register};

endmodule

// File: tb/tb_debug_display_ctrl.sv
// Directed bench for debug_display_ctrl with default parameters (6 digits, 20-bit value).
module tb_debug_display_ctrl;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, S9 = 7'b0010000,
                           SA = 7'b0001000, SB = 7'b0000011, SE = 7'b0000110,
                           SF = 7'b0001110, BL = 7'b1111111, DA = 7'b0111111;
    localparam logic [41:0] ALL1 = {42{1'b1}};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [48:0] pc_bus;
    logic [48:0] opcode_bus;
    logic [31:0] selected_register;
    logic [31:0] status_register;
    logic [9:0]  SW;
    logic [41:0] HEX;
    logic [9:0]  LEDR;
    logic        busy;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    logic found;

    debug_display_ctrl dut (
        .clk(clk), .rst_n(rst_n), .pc_bus(pc_bus), .opcode_bus(opcode_bus),
        .selected_register(selected_register), .status_register(status_register),
        .SW(SW), .HEX(HEX), .LEDR(LEDR), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [41:0] img(input logic [6:0] d5, d4, d3, d2, d1, d0);
        return {d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sync_capture(input string tag);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (busy === 1'b0) found = 1'b1;
            else tick(1);
        end
        check(tag, 64'(found), 64'd1);
    endtask

    initial begin
        rst_n             = 1'b0;
        SW                = 10'b10_0000_0000;
        selected_register = '0;
        status_register   = '0;
        pc_bus            = '0;
        opcode_bus        = '0;
        pc_bus[3*7 +: 7]      = 7'd42;
        pc_bus[5*7 +: 7]      = 7'd127;
        opcode_bus[0*7 +: 7]  = 7'h11;
        opcode_bus[3*7 +: 7]  = 7'h55;
        opcode_bus[5*7 +: 7]  = 7'h3C;

        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_hex", 64'(HEX), 64'(ALL1));
        check("reset_ledr", 64'(LEDR), 64'h011);

        // Stage 3 PC 42 decimal; exact commit latency
        SW    = 10'b10_0000_0011;
        rst_n = 1'b1;
        tick(7);
        check("lat_hex_early", 64'(HEX), 64'(ALL1));
        check("lat_busy", 64'(busy), 64'd1);
        check("stage3_ledr", 64'(LEDR), 64'h055);
        tick(1);
        check("stage3_hex", 64'(HEX), 64'(img(BL, BL, BL, BL, S4, S2)));
        check("commit_busy", 64'(busy), 64'd0);

        // Register hex BEEF
        SW = 10'b11_0100_0000;
        selected_register = 32'h000BEEF;
        tick(20);
        check("reg_hex_beef", 64'(HEX), 64'(img(BL, BL, SB, SE, SE, SF)));
        check("reg_ledr", 64'(LEDR), 64'h000);

        // Decimal boundaries
        SW = 10'b11_0000_0000;
        selected_register = 32'h000FFFFF;
        tick(20);
        check("dec_ovf_fffff", 64'(HEX), 64'({6{DA}}));
        selected_register = 32'd999999;
        tick(20);
        check("dec_999999", 64'(HEX), 64'({6{S9}}));
        selected_register = 32'd1000000;
        tick(20);
        check("dec_1000000", 64'(HEX), 64'({6{DA}}));
        selected_register = 32'd0;
        tick(20);
        check("dec_zero", 64'(HEX), 64'(img(BL, BL, BL, BL, BL, S0)));
        selected_register = 32'hFFF0_0007;
        tick(20);
        check("dec_trunc", 64'(HEX), 64'(img(BL, BL, BL, BL, BL, S7)));

        // Flags mode
        SW = 10'b10_1000_0000;
        status_register = 32'hA000_0000;
        tick(20);
        check("flags_1010", 64'(HEX), 64'(img(BL, BL, S1, S0, S1, S0)));
        check("flags_ledr", 64'(LEDR), 64'h011);
        SW = 10'b11_1100_0000;
        status_register = 32'h5FFF_FFFF;
        tick(20);
        check("flags_0101", 64'(HEX), 64'(img(BL, BL, S0, S1, S0, S1)));

        // Out-of-range stage, stage 5 in both radices
        SW = 10'b10_0000_0111;
        tick(20);
        check("stage7_hex", 64'(HEX), 64'(img(BL, BL, BL, BL, BL, S0)));
        check("stage7_ledr", 64'(LEDR), 64'h000);
        SW = 10'b10_0000_0101;
        tick(20);
        check("stage5_dec", 64'(HEX), 64'(img(BL, BL, BL, S1, S2, S7)));
        check("stage5_ledr", 64'(LEDR), 64'h03C);
        SW = 10'b10_0100_0101;
        tick(20);
        check("stage5_hex", 64'(HEX), 64'(img(BL, BL, BL, BL, S7, SF)));

        // Abort at third CONVERT cycle
        sync_capture("sync_abort");
        tick(3);
        SW = 10'b10_0100_0011;
        tick(1);
        check("abort_busy", 64'(busy), 64'd0);
        tick(5);
        check("abort_hold", 64'(HEX), 64'(img(BL, BL, BL, BL, S7, SF)));
        tick(2);
        check("abort_hold_late", 64'(HEX), 64'(img(BL, BL, BL, BL, S7, SF)));
        tick(1);
        check("abort_new", 64'(HEX), 64'(img(BL, BL, BL, BL, S2, SA)));

        // Disable forces all ones, image retained
        SW = 10'b00_0100_0011;
        tick(1);
        check("dis_hex", 64'(HEX), 64'(ALL1));
        check("dis_ledr", 64'(LEDR), 64'h3FF);
        tick(10);
        check("dis_busy", 64'(busy), 64'd0);
        SW = 10'b10_0100_0011;
        #1;
        check("retained", 64'(HEX), 64'(img(BL, BL, BL, BL, S2, SA)));

        // Asynchronous reset mid-CONVERT
        tick(1);
        sync_capture("sync_reset");
        tick(3);
        check("mid_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_hex", 64'(HEX), 64'(ALL1));
        check("arst_busy", 64'(busy), 64'd0);
        SW = 10'b00_0000_0000;
        #1;
        check("arst_dis_hex", 64'(HEX), 64'(ALL1));
        check("arst_dis_ledr", 64'(LEDR), 64'h3FF);
        @(negedge clk);
        SW = 10'b11_0000_0000;
        selected_register = 32'd123456;
        rst_n = 1'b1;
        tick(7);
        check("rel_early", 64'(HEX), 64'(ALL1));
        tick(1);
        check("rel_value", 64'(HEX), 64'(img(S1, S2, S3, S4, S5, S6)));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/debug_display_ctrl.md
DEBUG_DISPLAY_CTRL -- requirements
Module: debug_display_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 7, number of pipeline stages selectable for display (1..8).
REQ-002 SHALL have parameter PC_W, default 7, width of each stage PC field.
REQ-003 SHALL have parameter OP_W, default 7, width of each stage opcode field (OP_W <= 10).
REQ-004 SHALL have parameter NUM_DIGITS, default 6, number of 7-segment digits driven (4..8).
REQ-005 SHALL have parameter VAL_W, default 20, width of the value converted for display (PC_W <= VAL_W <= 32).
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst_n, input, 1, reset; one clock, reset asynchronous and active-low.
REQ-008 SHALL have port pc_bus, input, NUM_STAGES*PC_W, stage PCs; stage s at bits [s*PC_W +: PC_W].
REQ-009 SHALL have port opcode_bus, input, NUM_STAGES*OP_W, stage opcodes packed as pc_bus.
REQ-010 SHALL have port selected_register, input, 32, register-file readout.
REQ-011 SHALL have port status_register, input, 32, CPSR; flags N,Z,C,V at [31:28].
REQ-012 SHALL have port SW, input, 10: [9] display enable, [8] register mode, [7] flags mode, [6] hex radix, [5:3] reserved, [2:0] stage select.
REQ-013 SHALL have port HEX, output, NUM_DIGITS*7, active-low segments gfedcba; digit d at [d*7 +: 7].
REQ-014 SHALL have port LEDR, output, 10, opcode LEDs.
REQ-015 SHALL have port busy, output, 1, high while a conversion is in flight.

Function
REQ-016 SHALL encode digits 0-9 as 1000000,1111001,0100100,0110000,0011001,0010010,0000010,1111000,0000000,0010000; A-F as 0001000,0000011,1000110,0100001,0000110,0001110; blank 1111111; dash 0111111.
REQ-017 SHALL select value = selected_register[VAL_W-1:0] when SW[8]=1, else zero-extended PC of stage SW[2:0]; stage index >= NUM_STAGES yields value 0 and opcode 0.
REQ-018 SHALL run FSM CAPTURE -> CONVERT -> COMMIT -> CAPTURE continuously while SW[9]=1; FSM stays in CAPTURE and busy=0 while SW[9]=0.
REQ-019 CAPTURE (1 cycle) SHALL latch value, status[31:28] and SW into shadow registers and set busy=1.
REQ-020 CONVERT SHALL produce exactly one digit per cycle, LSD first, for NUM_DIGITS cycles: decimal digit = v%10, v <= v/10; hex digit = v[3:0], v <= v>>4.
REQ-021 COMMIT SHALL write all NUM_DIGITS digits to the output registers in one cycle (no partial update visible) and clear busy.
REQ-022 HEX SHALL change exactly NUM_DIGITS+2 cycles after the CAPTURE cycle edge, refresh period NUM_DIGITS+2 cycles.
REQ-023 Leading-zero digits above the most significant nonzero digit SHALL be blank; digit 0 always shows a numeral (value 0 -> "0").
REQ-024 Decimal value >= 10^NUM_DIGITS, or hex value >= 16^NUM_DIGITS, SHALL display dash on every digit.
REQ-025 Flags mode (SW[7]=1) SHALL show digits 3..0 = N,Z,C,V as 0/1 without zero blanking, higher digits blank, SW[6] and SW[8] ignored.
REQ-026 Any SW change versus the captured SW during CONVERT or COMMIT SHALL abort the conversion, leave HEX holding the last committed image, and return to CAPTURE next cycle.
REQ-027 SW[9]=0 SHALL force HEX to all ones and LEDR to all ones combinationally; committed image is retained.
REQ-028 SW[9]=1 SHALL drive LEDR = 0 when SW[8]=1, else {zero pad, selected opcode}, combinationally.

Reset
REQ-029 rst_n low SHALL immediately force FSM to CAPTURE, committed digits to blank, shadow registers to 0, busy to 0, regardless of clk.
REQ-030 Reset deasserted mid-conversion SHALL restart from CAPTURE on the first clk edge after release.

Verification
REQ-031 SW=10'b10_0000_0011, pc_bus stage3=7'd42 -> HEX after 8 cycles: digits0,1 = "2","4", digits2-5 blank; LEDR = stage3 opcode.
REQ-032 SW[9:8]=11, SW[6]=1, selected_register=32'h000BEEF -> HEX = blank,blank,"b","E","E","F" (d5..d0).
REQ-033 SW[9:8]=11 decimal, register 20'hFFFFF (1048575 >= 10^6) -> all six digits dash.
REQ-034 SW[9]=1, SW[7]=1, status[31:28]=4'b1010 -> d3..d0 = "1","0","1","0", d5,d4 blank.
REQ-035 Toggle SW[2:0] at cycle 3 of CONVERT -> HEX unchanged that period, new value committed 8 cycles after restart CAPTURE.
REQ-036 rst_n pulsed low mid-CONVERT -> HEX blank, busy=0 asynchronously; SW[9]=0 -> HEX and LEDR all ones.
